vga_timing_gen: RTL

Parametrised VGA/SVGA raster timing generator, the successor to our fixed-mode sync core. Every horizontal/vertical interval, the sync polarity and the counter width are parameters. It adds a run/idle enable, line/frame strobes and a frame counter, plus an optional prefetch coordinate port. It sits between the pixel clock domain's clocking block and the framebuffer reader / DAC output stage.

---
 rtl/vga_timing_pkg.sv | 37 +++
 rtl/vga_span_counter.sv | 30 +++
 rtl/vga_timing_gen.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared constants for the VGA raster timing generator.
// Holds the 640x480@60 default intervals, an 800x600@60 set, the
// IDLE/RUN state encoding and the frame counter width.
package vga_timing_pkg;

  // 640x480 @ 60 Hz (25.175 MHz pixel clock), negative syncs
  localparam int VGA640_H_ACTIVE  = 640;
  localparam int VGA640_H_FRONT   = 16;
  localparam int VGA640_H_SYNC    = 96;
  localparam int VGA640_H_BACK    = 48;
  localparam int VGA640_V_ACTIVE  = 480;
  localparam int VGA640_V_FRONT   = 10;
  localparam int VGA640_V_SYNC    = 2;
  localparam int VGA640_V_BACK    = 33;
  localparam bit VGA640_HSYNC_POL = 1'b0;
  localparam bit VGA640_VSYNC_POL = 1'b0;

  // 800x600 @ 60 Hz (40 MHz pixel clock), positive syncs
  localparam int SVGA800_H_ACTIVE  = 800;
  localparam int SVGA800_H_FRONT   = 40;
  localparam int SVGA800_H_SYNC    = 128;
  localparam int SVGA800_H_BACK    = 88;
  localparam int SVGA800_V_ACTIVE  = 600;
  localparam int SVGA800_V_FRONT   = 1;
  localparam int SVGA800_V_SYNC    = 4;
  localparam int SVGA800_V_BACK    = 23;
  localparam bit SVGA800_HSYNC_POL = 1'b1;
  localparam bit SVGA800_VSYNC_POL = 1'b1;

  localparam int FRAME_CNT_W = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } vga_state_t;

endpackage

// File: rtl/vga_span_counter.sv
// vga_span_counter: wrap counter 0..TOTAL-1 with synchronous clear to INIT,
// count enable and a terminal-count flag (count == TOTAL-1).
module vga_span_counter
  import vga_timing_pkg::*;
#(
  parameter int CW    = 11,
  parameter int TOTAL = 800,
  parameter int INIT  = 0
) (
  input  logic          pixel_clock,
  input  logic          reset_n,
  input  logic          clear,
  input  logic          step,
  output logic [CW-1:0] count,
  output logic          tc
);

  localparam logic [CW-1:0] LAST   = CW'(TOTAL - 1);
  localparam logic [CW-1:0] INIT_C = CW'(INIT);

  assign tc = (count == LAST);

  // Count position: clear wins, otherwise advance and wrap at TOTAL-1
  always_ff @(posedge pixel_clock or negedge reset_n) begin
    if (!reset_n)   count <= INIT_C;
    else if (clear) count <= INIT_C;
    else if (step)  count <= tc ? '0 : count + 1'b1;
  end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA/SVGA raster timing generator.
// Line/frame order is sync, back porch, active, front porch. All outputs are
// registered decodes of the (h,v) position held before the clock edge.
// Optional prefetch port enabled by defining VGA_TIMING_PREFETCH_EN.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE  = VGA640_H_ACTIVE,
  parameter int H_FRONT   = VGA640_H_FRONT,
  parameter int H_SYNC    = VGA640_H_SYNC,
  parameter int H_BACK    = VGA640_H_BACK,
  parameter int V_ACTIVE  = VGA640_V_ACTIVE,
  parameter int V_FRONT   = VGA640_V_FRONT,
  parameter int V_SYNC    = VGA640_V_SYNC,
  parameter int V_BACK    = VGA640_V_BACK,
  parameter bit HSYNC_POL = VGA640_HSYNC_POL,
  parameter bit VSYNC_POL = VGA640_VSYNC_POL,
  parameter int CW        = 11,
  parameter int PREFETCH  = 2
) (
  input  logic                   pixel_clock,
  input  logic                   reset_n,
  input  logic                   en,
  output logic                   hsync,
  output logic                   vsync,
  output logic                   blank,
  output logic                   de,
  output logic [CW-1:0]          x,
  output logic [CW-1:0]          y,
  output logic                   line_start,
  output logic                   frame_start,
  output logic [FRAME_CNT_W-1:0] frame_cnt
`ifdef VGA_TIMING_PREFETCH_EN
  ,
  output logic                   fetch_valid,
  output logic [CW-1:0]          fetch_x,
  output logic [CW-1:0]          fetch_y
`endif
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;

  localparam logic [CW-1:0] H_SYNC_C = CW'(H_SYNC);
  localparam logic [CW-1:0] V_SYNC_C = CW'(V_SYNC);
  localparam logic [CW-1:0] H_ACT_LO = CW'(H_SYNC + H_BACK);
  localparam logic [CW-1:0] H_ACT_HI = CW'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [CW-1:0] V_ACT_LO = CW'(V_SYNC + V_BACK);
  localparam logic [CW-1:0] V_ACT_HI = CW'(V_SYNC + V_BACK + V_ACTIVE);

  typedef struct packed {
    logic          de;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
  } pix_t;

  // Active-window decode shared by the display and prefetch paths
  function automatic pix_t pix_decode(input logic [CW-1:0] h, input logic [CW-1:0] v);
    pix_t p;
    p.de = (h >= H_ACT_LO) && (h < H_ACT_HI) && (v >= V_ACT_LO) && (v < V_ACT_HI);
    p.x  = p.de ? h - H_ACT_LO : '0;
    p.y  = p.de ? v - V_ACT_LO : '0;
    return p;
  endfunction

  vga_state_t    state, state_nxt;
  logic          go;
  logic          cnt_clear;
  logic [CW-1:0] h_cnt, v_cnt;
  logic          h_tc, v_tc;
  logic          wrap_p1;
  pix_t          pix_p0;

  // Counters only advance on an edge where RUN is held and en stays high;
  // the entry edge and every idle edge park them at the origin.
  assign go        = (state == ST_RUN) && en;
  assign cnt_clear = !go;
  assign pix_p0    = pix_decode(h_cnt, v_cnt);

  // State register
  always_ff @(posedge pixel_clock or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Next state: en is the only run/idle control
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (en)  state_nxt = ST_RUN;
      ST_RUN:  if (!en) state_nxt = ST_IDLE;
      default:          state_nxt = ST_IDLE;
    endcase
  end

  vga_span_counter #(.CW(CW), .TOTAL(H_TOTAL), .INIT(0)) u_h_cnt (
    .pixel_clock (pixel_clock),
    .reset_n     (reset_n),
    .clear       (cnt_clear),
    .step        (1'b1),
    .count       (h_cnt),
    .tc          (h_tc)
  );

  vga_span_counter #(.CW(CW), .TOTAL(V_TOTAL), .INIT(0)) u_v_cnt (
    .pixel_clock (pixel_clock),
    .reset_n     (reset_n),
    .clear       (cnt_clear),
    .step        (h_tc),
    .count       (v_cnt),
    .tc          (v_tc)
  );

  // ---- stage p0 -> p1: registered raster outputs ----
  // Register the decode of the held position, or idle values when not running
  always_ff @(posedge pixel_clock or negedge reset_n) begin
    if (!reset_n) begin
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
      blank       <= 1'b1;
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (go) begin
      hsync       <= (h_cnt < H_SYNC_C) ? HSYNC_POL : ~HSYNC_POL;
      vsync       <= (v_cnt < V_SYNC_C) ? VSYNC_POL : ~VSYNC_POL;
      blank       <= !pix_p0.de;
      de          <= pix_p0.de;
      x           <= pix_p0.x;
      y           <= pix_p0.y;
      line_start  <= (h_cnt == '0);
      frame_start <= (h_cnt == '0) && (v_cnt == '0);
    end else begin
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
      blank       <= 1'b1;
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

  // Frame counter: the wrap is remembered for one cycle so the increment
  // lands on the edge that raises frame_start, never on RUN entry.
  always_ff @(posedge pixel_clock or negedge reset_n) begin
    if (!reset_n) begin
      wrap_p1   <= 1'b0;
      frame_cnt <= '0;
    end else begin
      wrap_p1 <= go && h_tc && v_tc;
      if (go && wrap_p1) frame_cnt <= frame_cnt + 1'b1;
    end
  end

`ifdef VGA_TIMING_PREFETCH_EN
  logic [CW-1:0] hp_cnt, vp_cnt;
  logic          hp_tc, vp_tc;
  pix_t          fpix_p0;

  assign fpix_p0 = pix_decode(hp_cnt, vp_cnt);

  // Lookahead pair parks PREFETCH pixels ahead of the origin so it leads
  // the display counters by a constant distance from RUN entry onward.
  vga_span_counter #(.CW(CW), .TOTAL(H_TOTAL), .INIT(PREFETCH)) u_hp_cnt (
    .pixel_clock (pixel_clock),
    .reset_n     (reset_n),
    .clear       (cnt_clear),
    .step        (1'b1),
    .count       (hp_cnt),
    .tc          (hp_tc)
  );

  vga_span_counter #(.CW(CW), .TOTAL(V_TOTAL), .INIT(0)) u_vp_cnt (
    .pixel_clock (pixel_clock),
    .reset_n     (reset_n),
    .clear       (cnt_clear),
    .step        (hp_tc),
    .count       (vp_cnt),
    .tc          (vp_tc)
  );

  // ---- stage p0 -> p1: registered prefetch outputs ----
  // Register the lookahead decode, aligned with the raster outputs
  always_ff @(posedge pixel_clock or negedge reset_n) begin
    if (!reset_n) begin
      fetch_valid <= 1'b0;
      fetch_x     <= '0;
      fetch_y     <= '0;
    end else if (go) begin
      fetch_valid <= fpix_p0.de;
      fetch_x     <= fpix_p0.x;
      fetch_y     <= fpix_p0.y;
    end else begin
      fetch_valid <= 1'b0;
      fetch_x     <= '0;
      fetch_y     <= '0;
    end
  end
`endif

endmodule
